// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline.
// Resolves memory-wait, taken-branch, load-use and jump hazards with one action per cycle.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             ID_JOp,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Access,
    input  logic             mem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             freeze,
    output logic             MEM_WB_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0]       TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t     state;
    state_t     state_next;
    logic [7:0] wcnt;
    logic [7:0] wcnt_next;
    logic       stall_inc;
    logic       flush_inc;
    logic       timeout_set;

    logic h_mem;
    logic h_br;
    logic h_lu;
    logic h_j;

    // r0 is hard-wired, so a load "into" r0 never creates a real dependency.
    always_comb begin
        h_mem = MEM_Access & ~mem_ready;
        h_br  = EX_BranchTaken;
        h_lu  = EX_MemRead & (EX_rt != 5'd0) &
                ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt)));
        h_j   = ID_JOp;
    end

    always_comb begin
        state_next    = state;
        wcnt_next     = wcnt;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        timeout_set   = 1'b0;
        PC_write      = 1'b0;
        IF_ID_write   = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX_flush   = 1'b0;
        freeze        = 1'b0;
        MEM_WB_bubble = 1'b0;

        if (reset_n) begin
            case (state)
                RUN: begin
                    if (h_mem) begin
                        freeze        = 1'b1;
                        MEM_WB_bubble = 1'b1;
                        stall_inc     = 1'b1;
                        state_next    = MEM_WAIT;
                        wcnt_next     = 8'd1;
                    end else if (h_br) begin
                        PC_write    = 1'b1;
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (h_lu) begin
                        ID_EX_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (h_j) begin
                        PC_write    = 1'b1;
                        IF_ID_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else begin
                        PC_write    = 1'b1;
                        IF_ID_write = 1'b1;
                    end
                end

                // The ready cycle drops the bubble so the load result lands in MEM/WB.
                MEM_WAIT: begin
                    freeze    = 1'b1;
                    stall_inc = 1'b1;
                    if (mem_ready) begin
                        state_next = RUN;
                    end else begin
                        MEM_WB_bubble = 1'b1;
                        if (wcnt == TIMEOUT_VAL) begin
                            timeout_set = 1'b1;
                            state_next  = RUN;
                        end else begin
                            wcnt_next = wcnt + 8'd1;
                        end
                    end
                end

                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            wcnt        <= 8'd0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default-parameter instance and a small one
// (MEM_TIMEOUT=4, CNT_W=4) share stimulus; expected values are hand-computed constants.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       resetN;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       idUsesRt;
    logic       idJOp;
    logic       exMemRead;
    logic [4:0] exRt;
    logic       exBranchTaken;
    logic       memAccess;
    logic       memReady;

    logic        pcWriteBig, ifIdWriteBig, ifIdFlushBig, idExFlushBig, freezeBig, bubbleBig, timeoutBig;
    logic [15:0] stallBig, flushBig;
    logic        pcWriteSmall, ifIdWriteSmall, ifIdFlushSmall, idExFlushSmall, freezeSmall, bubbleSmall, timeoutSmall;
    logic [3:0]  stallSmall, flushSmall;

    logic [5:0] ctrlBig;
    logic [5:0] ctrlSmall;

    int totalChecks = 0;
    int badChecks   = 0;

    // Control vector order: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, freeze, MEM_WB_bubble}
    localparam logic [5:0] ALL    = 6'b111111;
    localparam logic [5:0] NO_IFW = 6'b101111;

    assign ctrlBig   = {pcWriteBig, ifIdWriteBig, ifIdFlushBig, idExFlushBig, freezeBig, bubbleBig};
    assign ctrlSmall = {pcWriteSmall, ifIdWriteSmall, ifIdFlushSmall, idExFlushSmall, freezeSmall, bubbleSmall};

    pipeline_hazard_ctrl uBig (
        .clk(clk), .reset_n(resetN),
        .ID_rs(idRs), .ID_rt(idRt), .ID_UsesRt(idUsesRt), .ID_JOp(idJOp),
        .EX_MemRead(exMemRead), .EX_rt(exRt), .EX_BranchTaken(exBranchTaken),
        .MEM_Access(memAccess), .mem_ready(memReady),
        .PC_write(pcWriteBig), .IF_ID_write(ifIdWriteBig), .IF_ID_flush(ifIdFlushBig),
        .ID_EX_flush(idExFlushBig), .freeze(freezeBig), .MEM_WB_bubble(bubbleBig),
        .mem_timeout(timeoutBig), .stall_cnt(stallBig), .flush_cnt(flushBig)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) uSmall (
        .clk(clk), .reset_n(resetN),
        .ID_rs(idRs), .ID_rt(idRt), .ID_UsesRt(idUsesRt), .ID_JOp(idJOp),
        .EX_MemRead(exMemRead), .EX_rt(exRt), .EX_BranchTaken(exBranchTaken),
        .MEM_Access(memAccess), .mem_ready(memReady),
        .PC_write(pcWriteSmall), .IF_ID_write(ifIdWriteSmall), .IF_ID_flush(ifIdFlushSmall),
        .ID_EX_flush(idExFlushSmall), .freeze(freezeSmall), .MEM_WB_bubble(bubbleSmall),
        .mem_timeout(timeoutSmall), .stall_cnt(stallSmall), .flush_cnt(flushSmall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic [5:0] expected, input logic [5:0] mask);
        checkOutput({tag, "_ctrl_big"},   32'(ctrlBig & mask),   32'(expected & mask));
        checkOutput({tag, "_ctrl_small"}, 32'(ctrlSmall & mask), 32'(expected & mask));
    endtask

    task automatic checkCounts(input string tag, input int stallB, input int flushB, input int stallS, input int flushS);
        checkOutput({tag, "_stall_big"},   32'(stallBig),   32'(stallB));
        checkOutput({tag, "_flush_big"},   32'(flushBig),   32'(flushB));
        checkOutput({tag, "_stall_small"}, 32'(stallSmall), 32'(stallS));
        checkOutput({tag, "_flush_small"}, 32'(flushSmall), 32'(flushS));
    endtask

    // Drives one cycle's inputs and lets the combinational outputs settle.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic jop, input logic memRead, input logic [4:0] ert,
                                 input logic br, input logic memAcc, input logic ready);
        idRs          = rs;
        idRt          = rt;
        idUsesRt      = usesRt;
        idJOp         = jop;
        exMemRead     = memRead;
        exRt          = ert;
        exBranchTaken = br;
        memAccess     = memAcc;
        memReady      = ready;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        $display("[TB] reset phase");
        checkCtrl("reset0", 6'b000000, ALL);
        tick();
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        checkCtrl("reset_hazards", 6'b000000, ALL);
        tick();
        checkCounts("reset", 0, 0, 0, 0);
        checkOutput("reset_timeout_small", 32'(timeoutSmall), 32'd0);

        resetN = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkCtrl("idle", 6'b110000, ALL);
        tick();
        checkCounts("idle", 0, 0, 0, 0);

        $display("[TB] load-use and flush priority");
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        checkCtrl("lu_rs", 6'b000100, ALL);
        tick();
        checkCounts("lu_rs", 1, 0, 1, 0);

        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkCtrl("after_lu", 6'b110000, ALL);
        tick();
        checkCounts("after_lu", 1, 0, 1, 0);

        applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        checkCtrl("lu_rt", 6'b000100, ALL);
        tick();
        checkCounts("lu_rt", 2, 0, 2, 0);

        applyStimulus(5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        checkCtrl("rt_unused", 6'b110000, ALL);
        tick();

        applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        checkCtrl("r0_no_stall", 6'b110000, ALL);
        tick();
        checkCounts("r0_no_stall", 2, 0, 2, 0);

        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkCtrl("jump", 6'b101000, NO_IFW);
        tick();
        checkCounts("jump", 2, 1, 2, 1);

        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
        checkCtrl("br_lu_j", 6'b101100, NO_IFW);
        tick();
        checkCounts("br_lu_j", 2, 2, 2, 2);

        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        checkCtrl("lu_j", 6'b000100, ALL);
        tick();
        checkCounts("lu_j", 3, 2, 3, 2);

        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1);
        checkCtrl("j_after_lu", 6'b101000, NO_IFW);
        tick();
        checkCounts("j_after_lu", 3, 3, 3, 3);

        $display("[TB] memory wait with ready on fourth cycle");
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        checkCtrl("mem_enter", 6'b000011, ALL);
        tick();
        checkCounts("mem_enter", 4, 3, 4, 3);
        checkCtrl("mem_wait1", 6'b000011, ALL);
        tick();
        checkCtrl("mem_wait2", 6'b000011, ALL);
        tick();
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1);
        checkCtrl("mem_ready", 6'b000010, ALL);
        tick();
        checkCounts("mem_done", 7, 3, 7, 3);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkCtrl("mem_back_run", 6'b110000, ALL);
        checkOutput("mem_no_timeout_small", 32'(timeoutSmall), 32'd0);
        tick();

        $display("[TB] memory timeout");
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("to_before_small", 32'(timeoutSmall), 32'd0);
        checkCtrl("to_wait4", 6'b000011, ALL);
        tick();
        checkOutput("to_set_small", 32'(timeoutSmall), 32'd1);
        checkOutput("to_stall_small", 32'(stallSmall), 32'd12);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("to_run_small", 32'(ctrlSmall), 32'(6'b110000));
        checkOutput("to_wait_big", 32'(ctrlBig), 32'(6'b000011));
        tick();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("big_ready", 32'(ctrlBig), 32'(6'b000010));
        tick();
        checkCounts("to_after", 14, 3, 12, 3);
        tick();
        checkCtrl("to_idle", 6'b110000, ALL);
        checkOutput("to_held_small", 32'(timeoutSmall), 32'd1);
        checkOutput("to_never_big", 32'(timeoutBig), 32'd0);

        $display("[TB] async reset during memory wait");
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        resetN = 1'b0;
        #1;
        checkCounts("async_rst", 0, 0, 0, 0);
        checkOutput("async_rst_timeout_small", 32'(timeoutSmall), 32'd0);
        checkCtrl("async_rst", 6'b000000, ALL);
        tick();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        resetN = 1'b1;
        #1;
        checkCtrl("rst_back_run", 6'b110000, ALL);

        $display("[TB] counter saturation");
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) checkOutput("sat_14_small", 32'(stallSmall), 32'd14);
        end
        checkCounts("sat_20", 20, 0, 15, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, max cycles in MEM_WAIT before timeout (1..255).
REQ-002 Parameter CNT_W, default 16, width of the stall and flush performance counters.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
REQ-006 ID_UsesRt  in  1  ID instruction reads rt (R-type, beq/bne, sw).
REQ-007 ID_JOp  in  1  ID holds j/jal/jr/jalr (the decoder's JOp).
REQ-008 EX_MemRead  in  1  EX holds a load; EX_rt  in  5  its destination.
REQ-009 EX_BranchTaken  in  1  branch in EX resolved taken this cycle.
REQ-010 MEM_Access  in  1  MEM holds lw/sw/lb; mem_ready  in  1  data memory done this cycle.
REQ-011 PC_write, IF_ID_write  out  1 each  enable PC and IF/ID updates.
REQ-012 IF_ID_flush, ID_EX_flush  out  1 each  replace stage register contents with a bubble.
REQ-013 freeze  out  1  hold ID/EX and EX/MEM; MEM_WB_bubble  out  1  write a bubble into MEM/WB.
REQ-014 mem_timeout  out  1  sticky error flag.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-016 FSM states: RUN, MEM_WAIT; 8-bit wait counter wcnt.
REQ-017 Hazard terms: H_mem = MEM_Access & ~mem_ready; H_br = EX_BranchTaken; H_lu = EX_MemRead & EX_rt!=0 & (EX_rt==ID_rs | (ID_UsesRt & EX_rt==ID_rt)); H_j = ID_JOp.
REQ-018 Control outputs are combinational from state and current inputs (zero latency); the counters and mem_timeout are registered.
REQ-019 Priority is H_mem > H_br > H_lu > H_j, and exactly one action applies per cycle.
REQ-020 RUN with no hazard: PC_write=1 and IF_ID_write=1; all flush, freeze and bubble outputs = 0.
REQ-021 RUN with H_mem: PC_write=0, IF_ID_write=0, freeze=1, MEM_WB_bubble=1; next state MEM_WAIT, wcnt<=1.
REQ-022 RUN with H_br (no H_mem): PC_write=1, IF_ID_flush=1, ID_EX_flush=1; flush_cnt += 1.
REQ-023 RUN with H_lu (no H_mem, no H_br): PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cnt += 1; the stall lasts exactly one cycle per load-use pair.
REQ-024 RUN with H_j only: PC_write=1, IF_ID_flush=1; flush_cnt += 1.
REQ-025 MEM_WAIT outputs: PC_write=0, IF_ID_write=0, freeze=1, MEM_WB_bubble=1; stall_cnt += 1 every cycle in this state; H_br, H_lu and H_j are ignored.
REQ-026 MEM_WAIT with mem_ready=1: outputs stay frozen that cycle, the MEM_WB bubble is suppressed (MEM_WB_bubble=0) so the result latches, and next state is RUN.
REQ-027 MEM_WAIT with mem_ready=0 and wcnt==MEM_TIMEOUT: set mem_timeout=1, next state RUN (access abandoned).
REQ-028 MEM_WAIT otherwise: wcnt increments.
REQ-029 mem_timeout stays set until reset.
REQ-030 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-031 The RUN cycle that enters MEM_WAIT counts toward stall_cnt.
REQ-032 H_br and H_j in the same cycle: the H_br action applies and flush_cnt increments by 1 only.
REQ-033 H_lu and H_j in the same cycle: stall only, no IF_ID_flush; the jump is handled on the following cycle.

Reset
REQ-034 While reset_n=0, asynchronously: state=RUN, wcnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
REQ-035 While reset_n=0: PC_write=0, IF_ID_write=0, and all flush, freeze and bubble outputs = 0.
REQ-036 Deassertion takes effect at the next rising clk; reset mid-MEM_WAIT abandons the wait.

Verification
REQ-037 Load-use: EX_MemRead=1, EX_rt=8, ID_rs=8 for one cycle -> PC_write=0, IF_ID_write=0, ID_EX_flush=1 that cycle; stall_cnt=1.
REQ-038 EX_rt=0 with a matching ID_rs=0 -> no stall.
REQ-039 Taken branch coincident with a load-use and ID_JOp -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1; flush_cnt +1; stall_cnt unchanged.
REQ-040 MEM_Access=1, mem_ready low for 3 cycles then high -> freeze=1 for 4 cycles, MEM_WB_bubble=1 for 3 cycles, then RUN; stall_cnt=4.
REQ-041 MEM_TIMEOUT=4, mem_ready never asserted -> mem_timeout=1 after the 4th MEM_WAIT cycle, state RUN, flag held until reset.
REQ-042 CNT_W=4 and 20 load-use stalls -> stall_cnt=15; assert reset_n=0 during MEM_WAIT -> all counters and state clear immediately, without a clock edge.
